// File: rtl/light_pkg.sv
// Shared types and default phase durations for the traffic-light road FSMs.
package light_pkg;
  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_RED    = 2'd2,
    PH_RSVD   = 2'd3
  } phase_e;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } timer_state_e;

  localparam int DEF_TICK_DIV = 10;
  localparam int DEF_CW       = 8;
  localparam int DEF_T_GREEN  = 30;
  localparam int DEF_T_YELLOW = 5;
  localparam int DEF_T_RED    = 2;
endpackage

// File: rtl/light_phase_timer_if.sv
// FSM <-> phase timer request/response bundle.
interface light_phase_timer_if #(parameter int CW = 8);
  import light_pkg::*;
  logic          clk_en;
  logic          start;
  phase_e        phase_sel;
  logic          abort;
  logic          busy;
  logic          timeout;
  logic [CW-1:0] remaining;
  logic          sel_err;

  modport master (output clk_en, start, phase_sel, abort,
                  input  busy, timeout, remaining, sel_err);
  modport slave  (input  clk_en, start, phase_sel, abort,
                  output busy, timeout, remaining, sel_err);
endinterface

// File: rtl/light_phase_timer_tick_prescaler.sv
// Divides the clk_en stream down to one tick per timer second while running.
module tick_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic clk_en,
  output logic tick
);
  localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)         cnt <= '0;
    else if (run && clk_en) cnt <= (cnt == LAST) ? 8'd0 : cnt + 8'd1;
  end

  assign tick = run && clk_en && (cnt == LAST);
endmodule

// File: rtl/light_phase_timer.sv
// Phase timer: loads a phase duration on start, counts seconds down, pulses timeout.
module light_phase_timer
  import light_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int CW       = DEF_CW,
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_YELLOW = DEF_T_YELLOW,
  parameter int T_RED    = DEF_T_RED
) (
  input  logic clk,
  input  logic rst,
  light_phase_timer_if.slave bus
);
  localparam int TMAX = (1 << CW) - 1;

  if (TICK_DIV < 1 || TICK_DIV > 255 ||
      T_GREEN  < 1 || T_GREEN  > TMAX ||
      T_YELLOW < 1 || T_YELLOW > TMAX ||
      T_RED    < 1 || T_RED    > TMAX) begin : g_param_chk
    $error("light_phase_timer: illegal TICK_DIV/T_* parameter");
  end

  timer_state_e  state, state_nx;
  logic [CW-1:0] rem, rem_nx, dur;
  logic          tick, load, bad_sel, expire, running;
  logic          timeout_q, timeout_nx, sel_err_q, sel_err_nx;

  assign running = (state == T_RUN);
  // abort wins over start; a reserved phase never loads
  assign load    = bus.start && !bus.abort && (bus.phase_sel != PH_RSVD);
  assign bad_sel = bus.start && !bus.abort && (bus.phase_sel == PH_RSVD);
  assign expire  = running && tick && (rem == CW'(1)) && !load && !bus.abort;

  always_comb begin
    dur = CW'(T_RED);
    unique case (bus.phase_sel)
      PH_GREEN:  dur = CW'(T_GREEN);
      PH_YELLOW: dur = CW'(T_YELLOW);
      default:   dur = CW'(T_RED);
    endcase
  end

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk    (clk),
    .rst    (rst),
    .clr    (bus.abort || load),
    .run    (running),
    .clk_en (bus.clk_en),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= T_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.abort)   state_nx = T_IDLE;
    else if (load)   state_nx = T_RUN;
    else if (expire) state_nx = T_IDLE;
  end

  always_comb begin
    rem_nx     = rem;
    timeout_nx = expire;
    sel_err_nx = bad_sel;
    if (bus.abort)            rem_nx = '0;
    else if (load)            rem_nx = dur;
    else if (running && tick) rem_nx = rem - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem       <= '0;
      timeout_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      rem       <= rem_nx;
      timeout_q <= timeout_nx;
      sel_err_q <= sel_err_nx;
    end
  end

  assign bus.busy      = running;
  assign bus.timeout   = timeout_q;
  assign bus.remaining = rem;
  assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_light_phase_timer.sv
// Directed + random bench for light_phase_timer against a pulse-count reference model.
module tb_light_phase_timer;
  import light_pkg::*;

  localparam int TD  = 2;
  localparam int CW  = 8;
  localparam int TG  = 4;
  localparam int TY  = 3;
  localparam int TR  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  light_phase_timer_if #(.CW(CW)) bus ();

  light_phase_timer #(
    .TICK_DIV(TD), .CW(CW), .T_GREEN(TG), .T_YELLOW(TY), .T_RED(TR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference: a running phase is just "clk_en pulses left until expiry".
  bit m_run  = 1'b0;
  int m_left = 0;
  bit m_to   = 1'b0;
  bit m_se   = 1'b0;

  function automatic int dur_of(input int sel);
    case (sel)
      0:       return TG;
      1:       return TY;
      default: return TR;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input int sel, input bit a, input bit ce);
    rst           = r;
    bus.start     = s;
    bus.phase_sel = phase_e'(sel[1:0]);
    bus.abort     = a;
    bus.clk_en    = ce;
    m_to = 1'b0;
    m_se = 1'b0;
    if (r || a) begin
      m_run = 1'b0; m_left = 0;
    end else if (s && sel != 3) begin
      m_run = 1'b1; m_left = dur_of(sel) * TD;
    end else begin
      m_se = s;
      if (m_run && ce) begin
        m_left--;
        if (m_left == 0) begin m_run = 1'b0; m_to = 1'b1; end
      end
    end
    @(posedge clk); #1;
    cyc++;
    chk("busy",      32'(bus.busy),      32'(m_run));
    chk("timeout",   32'(bus.timeout),   32'(m_to));
    chk("remaining", 32'(bus.remaining), m_run ? 32'((m_left + TD - 1) / TD) : 32'd0);
    chk("sel_err",   32'(bus.sel_err),   32'(m_se));
  endtask

  task automatic idle(input int n, input bit ce);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, ce);
  endtask

  initial begin
    int t0, seen;
    rst = 1'b1; bus.start = 1'b0; bus.phase_sel = PH_GREEN; bus.abort = 1'b0; bus.clk_en = 1'b0;

    // reset state, with a start pending to prove reset wins
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    idle(2, 1);

    // basic expiry: timeout exactly N*TD+1 cycles after start is sampled
    t0 = cyc; seen = -1;
    step(0, 1, 1, 0, 1);
    chk("rem_at_c1", 32'(bus.remaining), 32'(TY));
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 1);
      if (bus.timeout && seen < 0) seen = cyc - t0;
    end
    chk("expiry_latency", 32'(seen), 32'(TY * TD + 1));

    // reset mid-count, then no timeout for 20 cycles
    step(0, 1, 1, 0, 1);
    idle(2, 1);
    step(1, 0, 0, 0, 1);
    idle(20, 1);

    // gated clk_en: one pulse every 4th cycle
    step(0, 1, 2, 0, 1);
    for (int i = 0; i < 24; i++) step(0, 0, 0, 0, (i % 4) == 3);

    // restart on the very cycle that would expire
    step(0, 1, 2, 0, 1);
    for (int i = 0; i < 20 && !(m_run && m_left == 1); i++) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("restart_rem", 32'(bus.remaining), 32'(TG));
    idle(TG * TD + 3, 1);

    // abort beats start in the same cycle
    step(0, 1, 0, 0, 1);
    idle(3, 1);
    step(0, 1, 0, 1, 1);
    idle(TG * TD + 5, 1);

    // reserved phase, idle then running
    step(0, 1, 3, 0, 1);
    idle(2, 1);
    step(0, 1, 1, 0, 1);
    step(0, 1, 3, 0, 1);
    step(0, 1, 3, 0, 0);
    idle(TY * TD + 3, 1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 3)),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
